// File: rtl/bch_decode_seq_pkg.sv
// Shared types and helpers for the BCH decode sequencer: FSM state encoding,
// counter sizing and the codeword-length sanity rule.
package bch_decode_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WSYN  = 3'd3,
        ST_WKEY  = 3'd4,
        ST_CHIEN = 3'd5,
        ST_RESP  = 3'd6
    } seq_state_t;

    localparam int DEF_DATA_BITS = 5;
    localparam int DEF_T         = 3;
    localparam int DEF_CODE_BITS = 15;
    localparam int DEF_ERR_W     = 2;
    localparam int DEF_WDOG      = 255;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // A (possibly shortened) binary BCH code over GF(2^m) carries at most m*t parity bits.
    function automatic bit code_bits_ok(input int data_bits, input int t, input int code_bits);
        int m;
        m = $clog2(code_bits + 1);
        return (data_bits > 1) && (t > 0) && (code_bits > data_bits) &&
               ((code_bits - data_bits) <= m * t);
    endfunction

endpackage

// File: rtl/bch_seq_wdog.sv
// Loadable saturating wait-state counter; expired pulses on the WDOG-th
// consecutive counted cycle since the last clear. WDOG=0 disables it.
module bch_seq_wdog
    import bch_decode_seq_pkg::*;
#(
    parameter int WDOG = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = cnt_w(WDOG);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_eff;

    // clr marks the first cycle of a new state, so that cycle already counts from zero.
    assign cnt_eff = clr ? '0 : cnt_q;
    assign expired = (WDOG != 0) && inc && (cnt_eff == CW'(WDOG - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_eff != '1)) begin
            cnt_q <= cnt_eff + CW'(1);
        end else begin
            cnt_q <= cnt_eff;
        end
    end

endmodule

// File: rtl/bch_decode_seq.sv
// Sequencer for the serial BCH decode chain: streams one codeword into the
// syndrome unit, kicks the BMA, gathers the Chien error vector, returns data.
module bch_decode_seq
    import bch_decode_seq_pkg::*;
#(
    parameter int DATA_BITS = 5,
    parameter int T         = 3,
    parameter int CODE_BITS = 15,
    parameter int ERR_W     = 2,
    parameter int WDOG      = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CODE_BITS-1:0] req_code,
    output logic                 syn_start,
    input  logic                 syn_ready,
    output logic                 syn_data,
    input  logic                 syn_done,
    output logic                 key_start,
    input  logic                 key_ready,
    input  logic                 key_done,
    input  logic [ERR_W-1:0]     key_err_count,
    input  logic                 ch_first,
    input  logic                 ch_valid,
    input  logic                 ch_last,
    input  logic                 ch_err,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [ERR_W-1:0]     rsp_nerr,
    output logic                 rsp_fail,
    output seq_state_t           dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
    // req_ready is high only in IDLE, and rsp_valid/rsp_* hold stable until the transfer.

    localparam int CNT_W = cnt_w(CODE_BITS);

    if (!code_bits_ok(DATA_BITS, T, CODE_BITS)) begin : g_bad_code_bits
        $error("bch_decode_seq: CODE_BITS=%0d inconsistent with DATA_BITS=%0d, T=%0d",
               CODE_BITS, DATA_BITS, T);
    end
    if (ERR_W != cnt_w(T)) begin : g_bad_err_w
        $error("bch_decode_seq: ERR_W=%0d cannot hold error counts up to T=%0d", ERR_W, T);
    end

    seq_state_t           state_q;
    logic [CODE_BITS-1:0] code_q;
    logic [CODE_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_BITS-1:0] err_q;
    logic [ERR_W-1:0]     nerr_q;
    logic [ERR_W-1:0]     est_q;
    logic                 key_pend_q;
    logic                 last_q;
    logic                 new_q;
    logic                 wd_inc;
    logic                 wd_exp;
    logic [DATA_BITS-1:0] raw_data;

    assign raw_data  = code_q[CODE_BITS-1 -: DATA_BITS];
    assign dbg_state = state_q;
    assign wd_inc    = (state_q == ST_LOAD) || (state_q == ST_WSYN) ||
                       (state_q == ST_WKEY) || (state_q == ST_CHIEN);

    bch_seq_wdog #(.WDOG(WDOG)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (new_q),
        .inc     (wd_inc),
        .expired (wd_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            nerr_q     <= '0;
            est_q      <= '0;
            key_pend_q <= 1'b0;
            last_q     <= 1'b0;
            new_q      <= 1'b0;
            req_ready  <= 1'b1;
            syn_start  <= 1'b0;
            syn_data   <= 1'b0;
            key_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_nerr   <= '0;
            rsp_fail   <= 1'b0;
        end else begin
            syn_start <= 1'b0;
            key_start <= 1'b0;
            new_q     <= 1'b0;
            if (wd_exp) begin
                // Abort: report the undecoded data as a failure.
                state_q    <= ST_RESP;
                new_q      <= 1'b1;
                key_pend_q <= 1'b0;
                last_q     <= 1'b0;
                syn_data   <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_data   <= raw_data;
                rsp_nerr   <= '0;
                rsp_fail   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req_valid) begin
                            code_q     <= req_code;
                            shift_q    <= req_code;
                            err_q      <= '0;
                            nerr_q     <= '0;
                            est_q      <= '0;
                            key_pend_q <= 1'b0;
                            last_q     <= 1'b0;
                            req_ready  <= 1'b0;
                            state_q    <= ST_LOAD;
                            new_q      <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (syn_ready) begin
                            syn_start <= 1'b1;
                            syn_data  <= shift_q[CODE_BITS-1];
                            shift_q   <= {shift_q[CODE_BITS-2:0], 1'b0};
                            cnt_q     <= CNT_W'(1);
                            state_q   <= ST_SHIFT;
                            new_q     <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (cnt_q == CNT_W'(CODE_BITS)) begin
                            syn_data <= 1'b0;
                            state_q  <= ST_WSYN;
                            new_q    <= 1'b1;
                        end else begin
                            syn_data <= shift_q[CODE_BITS-1];
                            shift_q  <= {shift_q[CODE_BITS-2:0], 1'b0};
                            cnt_q    <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_WSYN: begin
                        if (syn_done) begin
                            state_q <= ST_WKEY;
                            new_q   <= 1'b1;
                            if (key_ready) key_start  <= 1'b1;
                            else           key_pend_q <= 1'b1;
                        end
                    end
                    ST_WKEY: begin
                        if (key_pend_q && key_ready) begin
                            key_start  <= 1'b1;
                            key_pend_q <= 1'b0;
                        end
                        // A key_done before the BMA was started cannot belong to this word.
                        if (key_done && !key_pend_q) begin
                            est_q   <= key_err_count;
                            state_q <= ST_CHIEN;
                            new_q   <= 1'b1;
                        end
                    end
                    ST_CHIEN: begin
                        if (last_q) begin
                            last_q    <= 1'b0;
                            state_q   <= ST_RESP;
                            new_q     <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_data  <= raw_data ^ err_q;
                            rsp_nerr  <= nerr_q;
                            rsp_fail  <= (nerr_q != est_q);
                        end else if (ch_first || ch_valid) begin
                            // Right-shift so the first Chien bit ends up in the data LSB.
                            if (ch_first) begin
                                err_q  <= {ch_err, {(DATA_BITS-1){1'b0}}};
                                nerr_q <= ERR_W'(ch_err);
                            end else begin
                                err_q <= {ch_err, err_q[DATA_BITS-1:1]};
                                if (ch_err && (nerr_q != '1)) nerr_q <= nerr_q + ERR_W'(1);
                            end
                            if (ch_valid && ch_last) last_q <= 1'b1;
                        end
                    end
                    ST_RESP: begin
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            rsp_data  <= '0;
                            rsp_nerr  <= '0;
                            rsp_fail  <= 1'b0;
                            req_ready <= 1'b1;
                            state_q   <= ST_IDLE;
                            new_q     <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bch_decode_seq.sv
// Bench for bch_decode_seq: behavioural syndrome/BMA/Chien chain around the
// sequencer, table-driven decode vectors plus watchdog and reset sequences.
module tb_bch_decode_seq;
    import bch_decode_seq_pkg::*;

    localparam int DATA_BITS = 5;
    localparam int T         = 3;
    localparam int CODE_BITS = 15;
    localparam int ERR_W     = 2;
    localparam int WDOG      = 16;
    localparam int W         = DATA_BITS + ERR_W + 1;
    localparam int PAR_BITS  = CODE_BITS - DATA_BITS;
    // bch_encode(5'b00011): g(x)=0x537, parity = (x+1)x^10 mod g = 0x359.
    localparam logic [CODE_BITS-1:0] GOLDEN = 15'h0F59;

    localparam int M_IDLE = 0, M_COLLECT = 1, M_SYNLAT = 2, M_KEYWAIT = 3, M_BMA = 4, M_CHIEN = 5;

    logic                 clk;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic [CODE_BITS-1:0] req_code;
    logic                 syn_start;
    logic                 syn_ready;
    logic                 syn_data;
    logic                 syn_done;
    logic                 key_start;
    logic                 key_ready;
    logic                 key_done;
    logic [ERR_W-1:0]     key_err_count;
    logic                 ch_first;
    logic                 ch_valid;
    logic                 ch_last;
    logic                 ch_err;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_BITS-1:0] rsp_data;
    logic [ERR_W-1:0]     rsp_nerr;
    logic                 rsp_fail;
    seq_state_t           dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // Chain model state and knobs set by the test sequences.
    int                   syn_hold_cfg = 0;
    int                   key_busy_cfg = 0;
    logic                 m_stub       = 1'b0;
    int                   syn_cnt      = 0;
    int                   key_cnt      = 0;
    int                   m_phase, m_hold, m_nbits, m_dly, m_busy, m_idx;
    logic [CODE_BITS-1:0] m_rx;
    logic [CODE_BITS-1:0] m_err;

    typedef struct {
        logic [CODE_BITS-1:0] code;
        int                   syn_hold;
        int                   key_busy;
        int                   hold;
        logic [DATA_BITS-1:0] exp_data;
        logic [ERR_W-1:0]     exp_nerr;
        logic                 exp_fail;
    } vec_t;

    vec_t vecs[7];

    bch_decode_seq #(
        .DATA_BITS(DATA_BITS), .T(T), .CODE_BITS(CODE_BITS), .ERR_W(ERR_W), .WDOG(WDOG)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
        .syn_start(syn_start), .syn_ready(syn_ready), .syn_data(syn_data), .syn_done(syn_done),
        .key_start(key_start), .key_ready(key_ready), .key_done(key_done),
        .key_err_count(key_err_count),
        .ch_first(ch_first), .ch_valid(ch_valid), .ch_last(ch_last), .ch_err(ch_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_nerr(rsp_nerr), .rsp_fail(rsp_fail), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    // ---------------- chain model (drives at posedge+2) ----------------
    initial begin
        int pc;
        syn_ready = 1'b1; syn_done = 1'b0; key_ready = 1'b1; key_done = 1'b0;
        key_err_count = '0; ch_first = 1'b0; ch_valid = 1'b0; ch_last = 1'b0; ch_err = 1'b0;
        m_phase = M_IDLE; m_hold = 0; m_nbits = 0; m_dly = 0; m_busy = 0; m_idx = 0;
        m_rx = '0; m_err = '0;
        forever begin
            @(posedge clk); #2;
            syn_done = 1'b0; key_done = 1'b0;
            ch_first = 1'b0; ch_valid = 1'b0; ch_last = 1'b0; ch_err = 1'b0;
            if (!rst) begin
                m_phase = M_IDLE; m_hold = 0; syn_ready = 1'b1; key_ready = 1'b1;
            end else begin
                if (syn_start) syn_cnt++;
                if (key_start) key_cnt++;
                case (m_phase)
                    M_IDLE: begin
                        if (req_valid && req_ready) m_hold = syn_hold_cfg;
                        if (syn_start && syn_ready) begin
                            m_rx = CODE_BITS'(syn_data); m_nbits = 1;
                            syn_ready = 1'b0; m_phase = M_COLLECT;
                        end else if (m_hold > 0) begin
                            syn_ready = 1'b0; m_hold--;
                        end else begin
                            syn_ready = 1'b1;
                        end
                    end
                    M_COLLECT: begin
                        m_rx = {m_rx[CODE_BITS-2:0], syn_data};
                        m_nbits++;
                        if (m_nbits == CODE_BITS) begin m_dly = 2; m_phase = M_SYNLAT; end
                    end
                    M_SYNLAT: begin
                        if (m_dly == 0) begin
                            syn_done = 1'b1;
                            m_err = m_rx ^ GOLDEN;
                            m_busy = key_busy_cfg;
                            key_ready = (m_busy == 0);
                            m_phase = M_KEYWAIT;
                        end else m_dly--;
                    end
                    M_KEYWAIT: begin
                        if (key_start) begin
                            key_ready = 1'b0; m_dly = 3; m_phase = M_BMA;
                        end else begin
                            if (m_busy > 0) m_busy--;
                            key_ready = (m_busy == 0);
                        end
                    end
                    M_BMA: begin
                        if (m_dly > 0) m_dly--;
                        else if (!m_stub) begin
                            pc = $countones(m_err);
                            key_err_count = (pc > T) ? '0 : ERR_W'(pc);
                            key_done = 1'b1; m_idx = 0; m_phase = M_CHIEN;
                        end
                    end
                    M_CHIEN: begin
                        ch_valid = 1'b1;
                        ch_first = (m_idx == 0);
                        ch_last  = (m_idx == DATA_BITS - 1);
                        ch_err   = m_err[PAR_BITS + m_idx];
                        m_idx++;
                        if (m_idx == DATA_BITS) begin
                            key_ready = 1'b1; syn_ready = 1'b1; m_phase = M_IDLE;
                        end
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_req(input logic [CODE_BITS-1:0] code, input int sh, input int kb,
                            output bit ok);
        int n = 0;
        while (!req_ready && n < 100) begin cyc(1); n++; end
        ok = req_ready;
        if (!ok) return;
        syn_hold_cfg = sh; key_busy_cfg = kb;
        req_code = code; req_valid = 1'b1;
        cyc(1);
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n, s0, k0, bad;
        bit ok;
        logic [W-1:0] exp, snap;
        s0 = syn_cnt; k0 = key_cnt;
        send_req(v.code, v.syn_hold, v.key_busy, ok);
        check($sformatf("v%0d req_ready_wait", idx), 32'(ok), 32'd1);
        if (!ok) return;
        exp_q.push_back({v.exp_data, v.exp_nerr, v.exp_fail});
        n = 0;
        while (!rsp_valid && n < 300) begin cyc(1); n++; end
        check($sformatf("v%0d rsp_valid_wait", idx), 32'(rsp_valid), 32'd1);
        exp = exp_q.pop_front();
        if (!rsp_valid) return;
        check($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(exp[W-1 -: DATA_BITS]));
        check($sformatf("v%0d rsp_nerr", idx), 32'(rsp_nerr), 32'(exp[ERR_W:1]));
        check($sformatf("v%0d rsp_fail", idx), 32'(rsp_fail), 32'(exp[0]));
        check($sformatf("v%0d syn_start_pulses", idx), 32'(syn_cnt - s0), 32'd1);
        check($sformatf("v%0d key_start_pulses", idx), 32'(key_cnt - k0), 32'd1);
        snap = {rsp_data, rsp_nerr, rsp_fail};
        bad = 0;
        for (int i = 0; i < v.hold; i++) begin
            cyc(1);
            if (!rsp_valid || req_ready || ({rsp_data, rsp_nerr, rsp_fail} != snap)) bad++;
        end
        if (v.hold > 0) check($sformatf("v%0d rsp_hold_unstable_cycles", idx), 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        check($sformatf("v%0d req_ready_at_accept", idx), 32'(req_ready), 32'd0);
        cyc(1);
        rsp_ready = 1'b0;
        check($sformatf("v%0d req_ready_after_accept", idx), 32'(req_ready), 32'd1);
        check($sformatf("v%0d rsp_valid_after_accept", idx), 32'(rsp_valid), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, start_cyc;
        bit ok;
        vecs[0] = '{GOLDEN,           0, 0, 0,  5'b00011, 2'd0, 1'b0};
        vecs[1] = '{GOLDEN ^ 15'h3000, 2, 0, 0,  5'b00011, 2'd2, 1'b0};
        vecs[2] = '{GOLDEN ^ 15'h0007, 0, 3, 0,  5'b00011, 2'd0, 1'b1};
        vecs[3] = '{GOLDEN ^ 15'h4000, 0, 0, 20, 5'b00011, 2'd1, 1'b0};
        vecs[4] = '{GOLDEN ^ 15'h0401, 1, 2, 0,  5'b00011, 2'd1, 1'b1};
        vecs[5] = '{GOLDEN ^ 15'h7000, 0, 0, 0,  5'b00011, 2'd3, 1'b0};
        vecs[6] = '{GOLDEN ^ 15'h7C00, 0, 0, 0,  5'b00011, 2'd3, 1'b1};

        rst = 1'b0; req_valid = 1'b0; req_code = '0; rsp_ready = 1'b0;
        cyc(3);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset syn_start", 32'(syn_start), 32'd0);
        check("reset key_start", 32'(key_start), 32'd0);
        check("reset syn_data",  32'(syn_data),  32'd0);
        check("reset rsp_bus",   32'({rsp_data, rsp_nerr, rsp_fail}), 32'd0);
        rst = 1'b1;
        cyc(2);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Watchdog: BMA never answers; abort must land exactly WDOG cycles after WKEY entry.
        m_stub = 1'b1;
        send_req(GOLDEN, 0, 0, ok);
        check("wdog req_accept", 32'(ok), 32'd1);
        n = 0;
        while (dbg_state != ST_WKEY && n < 200) begin cyc(1); n++; end
        check("wdog reached_wkey", 32'(dbg_state == ST_WKEY), 32'd1);
        start_cyc = 0;
        while (!rsp_valid && start_cyc < 100) begin cyc(1); start_cyc++; end
        check("wdog abort_latency", 32'(start_cyc), 32'(WDOG));
        check("wdog rsp_fail", 32'(rsp_fail), 32'd1);
        check("wdog rsp_nerr", 32'(rsp_nerr), 32'd0);
        check("wdog rsp_data_raw", 32'(rsp_data), 32'(GOLDEN[CODE_BITS-1 -: DATA_BITS]));
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        m_stub = 1'b0;
        cyc(2);

        // Reset in the middle of the serial shift (bit 7).
        send_req(GOLDEN, 0, 0, ok);
        check("midrst req_accept", 32'(ok), 32'd1);
        n = 0;
        while (!syn_start && n < 50) begin cyc(1); n++; end
        check("midrst syn_start_seen", 32'(syn_start), 32'd1);
        cyc(6);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("midrst req_ready", 32'(req_ready), 32'd1);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst syn_data", 32'(syn_data), 32'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (rsp_valid || syn_start || key_start) n++;
        end
        check("midrst no_activity_cycles", 32'(n), 32'd0);
        run_vec(7, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
